// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight register writes by age and latency,
// producing the issue stall and per-source bypass distance for the X-stage muxes.
module reg_scoreboard #(
  parameter int NREGS  = 32,
  parameter int ADDRW  = $clog2(NREGS),
  parameter int RETIRE = 4,
  parameter int AGEW   = $clog2(RETIRE + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_iss_valid,
  input  logic [ADDRW-1:0] i_iss_rs1,
  input  logic [ADDRW-1:0] i_iss_rs2,
  input  logic             i_iss_use_rs1,
  input  logic             i_iss_use_rs2,
  input  logic [ADDRW-1:0] i_iss_rd,
  input  logic             i_iss_wen,
  input  logic [AGEW-1:0]  i_iss_lat,
  input  logic             i_kill,
  output logic             o_iss_ready,
  output logic             o_stall,
  output logic [AGEW-1:0]  o_rs1_age,
  output logic [AGEW-1:0]  o_rs2_age,
  output logic [ADDRW:0]   o_pending_cnt
);

  localparam logic [AGEW-1:0] AGE_ONE = AGEW'(1);
  localparam logic [AGEW-1:0] AGE_RET = AGEW'(RETIRE);

  logic [NREGS-1:0] r_v;
  logic [AGEW-1:0]  r_age [NREGS];
  logic [AGEW-1:0]  r_lat [NREGS];
  logic             r_sh_v;
  logic [ADDRW-1:0] r_sh_rd;
  logic [AGEW-1:0]  r_sh_age;
  logic [AGEW-1:0]  r_sh_lat;
  logic             r_last_fire;
  logic [ADDRW-1:0] r_last_rd;
  logic [ADDRW:0]   r_pending_cnt;

  logic [NREGS-1:0] w_v_nx;
  logic [AGEW-1:0]  w_age_nx [NREGS];
  logic [AGEW-1:0]  w_lat_nx [NREGS];
  logic             w_sh_v_nx;
  logic [ADDRW-1:0] w_sh_rd_nx;
  logic [AGEW-1:0]  w_sh_age_nx;
  logic [AGEW-1:0]  w_sh_lat_nx;
  logic [ADDRW:0]   w_cnt_nx;
  logic             w_src1_pend;
  logic             w_src2_pend;
  logic             w_haz1;
  logic             w_haz2;
  logic             w_fire;

  assign w_src1_pend   = i_iss_use_rs1 && (i_iss_rs1 != '0) && r_v[i_iss_rs1];
  assign w_src2_pend   = i_iss_use_rs2 && (i_iss_rs2 != '0) && r_v[i_iss_rs2];
  assign w_haz1        = w_src1_pend && (r_age[i_iss_rs1] < r_lat[i_iss_rs1]);
  assign w_haz2        = w_src2_pend && (r_age[i_iss_rs2] < r_lat[i_iss_rs2]);
  assign o_iss_ready   = !(w_haz1 || w_haz2);
  assign o_stall       = i_iss_valid && !o_iss_ready;
  assign o_rs1_age     = w_src1_pend ? r_age[i_iss_rs1] : '0;
  assign o_rs2_age     = w_src2_pend ? r_age[i_iss_rs2] : '0;
  assign o_pending_cnt = r_pending_cnt;
  assign w_fire        = i_iss_valid && o_iss_ready;

  // Order within one edge: age/retire, then kill (restore), then allocate.
  always_comb begin
    w_v_nx      = r_v;
    w_age_nx    = r_age;
    w_lat_nx    = r_lat;
    w_sh_v_nx   = r_sh_v;
    w_sh_rd_nx  = r_sh_rd;
    w_sh_age_nx = r_sh_age;
    w_sh_lat_nx = r_sh_lat;
    w_cnt_nx    = '0;

    for (int r = 1; r < NREGS; r++) begin
      if (r_v[r]) begin
        w_age_nx[r] = r_age[r] + AGE_ONE;
        if (w_age_nx[r] == AGE_RET) w_v_nx[r] = 1'b0;
      end
    end
    if (r_sh_v) begin
      w_sh_age_nx = r_sh_age + AGE_ONE;
      if (w_sh_age_nx == AGE_RET) w_sh_v_nx = 1'b0;
    end

    if (i_kill && r_last_fire && (r_last_rd != '0)) begin
      w_v_nx[r_last_rd] = 1'b0;
      if (w_sh_v_nx && (r_sh_rd == r_last_rd)) begin
        w_v_nx[r_last_rd]   = 1'b1;
        w_age_nx[r_last_rd] = w_sh_age_nx;
        w_lat_nx[r_last_rd] = r_sh_lat;
        w_sh_v_nx           = 1'b0;
      end
    end

    // A still-live older writer is parked in the shadow so a kill can bring it back.
    if (w_fire && i_iss_wen && (i_iss_rd != '0)) begin
      if (w_v_nx[i_iss_rd]) begin
        w_sh_v_nx   = 1'b1;
        w_sh_rd_nx  = i_iss_rd;
        w_sh_age_nx = w_age_nx[i_iss_rd];
        w_sh_lat_nx = w_lat_nx[i_iss_rd];
      end else begin
        w_sh_v_nx = 1'b0;
      end
      w_v_nx[i_iss_rd]   = 1'b1;
      w_age_nx[i_iss_rd] = AGE_ONE;
      w_lat_nx[i_iss_rd] = i_iss_lat;
    end

    for (int r = 1; r < NREGS; r++) w_cnt_nx = w_cnt_nx + (ADDRW+1)'(w_v_nx[r]);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_v <= '0;
      for (int r = 0; r < NREGS; r++) begin
        r_age[r] <= '0;
        r_lat[r] <= '0;
      end
      r_sh_v        <= 1'b0;
      r_sh_rd       <= '0;
      r_sh_age      <= '0;
      r_sh_lat      <= '0;
      r_last_fire   <= 1'b0;
      r_last_rd     <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_v           <= w_v_nx;
      r_age         <= w_age_nx;
      r_lat         <= w_lat_nx;
      r_sh_v        <= w_sh_v_nx;
      r_sh_rd       <= w_sh_rd_nx;
      r_sh_age      <= w_sh_age_nx;
      r_sh_lat      <= w_sh_lat_nx;
      r_last_fire   <= w_fire;
      r_last_rd     <= i_iss_wen ? i_iss_rd : '0;
      r_pending_cnt <= w_cnt_nx;
    end
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised successor to the fixed-compare load-use and write-data stall logic in the 5-stage core.
- Tracks each in-flight register write with a per-register valid/age/latency entry. It generalises hazard detection to any register count, any producer latency (ALU, load, multi-cycle ops) and any retire depth.
- Sits beside the decoder in D. It emits the issue stall and, per source operand, the bypass distance the X-stage operand muxes use.

Parameters:
- NREGS, 32, architectural register count; register 0 is hardwired zero and never tracked.
- ADDRW, $clog2(NREGS), register address width.
- RETIRE, 4, age at which a producer's value is in the register file; its entry is then freed.
- AGEW, $clog2(RETIRE+1), width of the age and latency fields.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- iss_valid  in  1  instruction in D requests issue.
- iss_rs1  in  ADDRW  source 1 address.
- iss_rs2  in  ADDRW  source 2 address.
- iss_use_rs1  in  1  instruction reads rs1.
- iss_use_rs2  in  1  instruction reads rs2.
- iss_rd  in  ADDRW  destination address.
- iss_wen  in  1  instruction writes rd.
- iss_lat  in  AGEW  age at which the result becomes bypassable (1 = ALU, 2 = load); range 1..RETIRE.
- kill  in  1  squash the instruction that fired on the previous cycle (branch taken).
- iss_ready  out  1  no RAW hazard on the current request.
- stall  out  1  iss_valid && !iss_ready.
- rs1_age  out  AGEW  age of the pending producer of rs1; 0 = read the register file.
- rs2_age  out  AGEW  age of the pending producer of rs2; 0 = read the register file.
- pending_cnt  out  ADDRW+1  number of valid entries.

Behaviour:
- State per register r in 1..NREGS-1: v[r], age[r], lat[r].
- Shadow state: sh_v, sh_rd, sh_age, sh_lat, plus last_fire and last_rd.
- Reset (async, reset==0): every v, sh_v and last_fire = 0. Outputs then read iss_ready=1, stall=0, rs*_age=0, pending_cnt=0.
- fire = iss_valid && iss_ready.
- Ageing, every cycle: each valid entry increments age. If the incremented age equals RETIRE, v clears on that edge. The shadow entry ages and retires the same way.
- Allocate, on fire with iss_wen && iss_rd!=0: entry iss_rd is set to v=1, age=1, lat=iss_lat.
  - If that entry was already valid and not retiring this edge, its old contents (post-increment) move to the shadow. Otherwise sh_v=0.
  - WAW: the newest writer owns the entry.
- Hazard, combinational, for source s with use_s && s!=0 && v[s]: hazard when age[s] < lat[s]. Then rs_age = age[s]; otherwise rs_age = 0.
- iss_ready = !(hazard_rs1 || hazard_rs2).
- Examples:
  - ALU producer (lat 1) at age 1: no stall; rs_age=1 means MX bypass next cycle.
  - Load (lat 2) at age 1: exactly one stall cycle, then rs_age=2 (WX).
- Kill, when kill && last_fire && last_rd!=0: entry last_rd clears. If sh_v && sh_rd==last_rd, the shadow is restored into that entry with its aged values, and sh_v clears.
  - kill with last_fire=0 is ignored.
  - kill and fire in the same cycle: kill applies to the older instruction; the new allocation then proceeds on the same edge, and the new write wins on an address collision.
- Same-edge retire and allocate on the same register: the allocation wins.
- pending_cnt is registered and counts v[1..NREGS-1] after the edge. The shadow is not counted.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: all outputs are combinational from registered state plus the current request. There is no added cycle.

Test Plan:
- Reset, then issue ADD rd=5 (lat 1), then consumer rs1=5 on the next cycle → iss_ready=1, rs1_age=1. Two cycles later the consumer sees rs1_age=2. At age 4 the entry is freed and pending_cnt returns to 0.
- Load rd=7 (lat 2), then consumer rs2=7 (use_rs2=1) on the next cycle → stall=1 for exactly one cycle. The following cycle gives iss_ready=1, rs2_age=2.
- Load rd=7, then consumer with use_rs2=0, rs2=7 → no stall. rs1=0 or rd=0 never produces a hazard or allocates an entry.
- ADD rd=3 (lat 1), then LW rd=3 (lat 2), then kill the next cycle → entry 3 is restored from the shadow with age=3, lat=1. A consumer of x3 sees iss_ready=1, rs1_age=3.
- kill asserted together with a fire of rd=4, where the killed instruction had rd=4 → after the edge v[4]=1, age=1, with the new lat. pending_cnt is unchanged.
- With 3 entries valid, drop reset low between clock edges → all outputs reset immediately. After release, a consumer of any register issues with no stall.
